// File: rtl/noise_shaper.sv
// First-order error-feedback requantizer: n-bit signed samples in, m-bit signed samples out.
// Latency 1 cycle; one-deep output register, in_ready = !out_valid || out_ready.
module noise_shaper #(
  parameter int n = 16,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clr,
  output logic [m-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sat,
  output logic [n-1:0] err
);

  localparam int SH = n - m;
  localparam logic [n:0] RND = (n+1)'(2 ** (SH - 1));

  logic [m-1:0] out_data_q;
  logic         out_valid_q;
  logic         out_sat_q;
  logic [n-1:0] err_q, err_d;

  logic         accept;
  logic [n-1:0] fb;
  logic [n:0]   s;
  logic         s_ovf;
  logic [n-1:0] ss;
  logic [n:0]   rs;
  logic [m:0]   q;
  logic         q_ovf;
  logic [m-1:0] qs;
  logic [n:0]   e_wide;
  logic         unused_bits;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    fb    = clr ? '0 : err_q;
    s     = {in_data[n-1], in_data} + {fb[n-1], fb};
    s_ovf = s[n] ^ s[n-1];
    ss    = s_ovf ? {s[n], {(n-1){~s[n]}}} : s[n-1:0];
    // Rounding sum kept at n+1 bits so the carry out of the top is preserved.
    rs    = {ss[n-1], ss} + RND;
    q     = rs[n:SH];
    q_ovf = q[m] ^ q[m-1];
    qs    = q_ovf ? {q[m], {(m-1){~q[m]}}} : q[m-1:0];
    e_wide = {ss[n-1], ss} - {qs[m-1], qs, {SH{1'b0}}};
    if (accept) begin
      err_d = e_wide[n-1:0];
    end else if (clr) begin
      err_d = '0;
    end else begin
      err_d = err_q;
    end
  end

  assign unused_bits = ^{rs[SH-1:0], e_wide[n]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      if (accept) begin
        out_data_q  <= qs;
        out_sat_q   <= s_ovf || q_ovf;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      err_q <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_noise_shaper.sv
// Bench for noise_shaper at n=8, m=4: reference model plus expected-output queue.
module tb_noise_shaper;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sat;
  logic [7:0] err;

  noise_shaper #(.n(8), .m(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   m_err;
  bit   m_vld;
  int   total;
  int   bad;

  int dtab[6] = '{0, 1, 0, 0, 1, 0};
  int etab[6] = '{5, -6, -1, 4, -7, -2};

  // Drives one cycle and advances the reference model; returns at edge+1.
  task automatic drive(input bit v, input int d, input bit ordy, input bit c);
    int fb, s, ss, q, qs;
    bit acc;
    exp_t e;
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = ordy;
    clr       = c;
    acc = v && (!m_vld || ordy);
    if (m_vld && ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) begin
      fb = c ? 0 : m_err;
      s  = d + fb;
      ss = (s > 127) ? 127 : (s < -128) ? -128 : s;
      q  = (ss + 8) >>> 4;
      qs = (q > 7) ? 7 : (q < -8) ? -8 : q;
      m_err = ss - qs * 16;
      e.d = 4'(qs);
      e.s = (s != ss) || (q != qs);
      exp_q.push_back(e);
      m_vld = 1'b1;
    end else begin
      if (c) m_err = 0;
      if (m_vld && ordy) m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data: got %0h want 0", out_data); end
    if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %0b want 0", out_sat); end
    if (err !== 8'h00) begin bad++; $display("FAIL reset_err: got %0h want 0", err); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    m_err = 0; m_vld = 1'b0; exp_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dc_stream();
    int sum;
    logic [3:0] d4;
    logic [7:0] e8;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5, 1'b1, 1'b0);
      total += 3;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL dc_valid[%0d]: got %0b want 1", i, out_valid); end
      if (out_data !== exp_q[0].d) begin bad++; $display("FAIL dc_data[%0d]: got %0h want %0h", i, out_data, exp_q[0].d); end
      if (err !== 8'(m_err)) begin bad++; $display("FAIL dc_err[%0d]: got %0h want %0h", i, err, 8'(m_err)); end
      if (i < 6) begin
        d4 = 4'(dtab[i]);
        e8 = 8'(etab[i]);
        total += 2;
        if (out_data !== d4) begin bad++; $display("FAIL dc_tab_data[%0d]: got %0h want %0h", i, out_data, d4); end
        if (err !== e8) begin bad++; $display("FAIL dc_tab_err[%0d]: got %0h want %0h", i, err, e8); end
      end
      sum += $signed(out_data);
    end
    total++;
    if (sum != 5) begin bad++; $display("FAIL dc_sum16: got %0d want 5", sum); end
  endtask

  task automatic test_clear();
    drive(1'b1, 5, 1'b1, 1'b0);
    drive(1'b1, 5, 1'b1, 1'b0);
    total++;
    if (err !== 8'hFA) begin bad++; $display("FAIL clr_pre_err: got %0h want fa", err); end
    drive(1'b1, 5, 1'b1, 1'b1);
    total += 3;
    if (out_data !== 4'h0) begin bad++; $display("FAIL clr_acc_data: got %0h want 0", out_data); end
    if (err !== 8'h05) begin bad++; $display("FAIL clr_acc_err: got %0h want 05", err); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_acc_valid: got %0b want 1", out_valid); end
    drive(1'b0, 0, 1'b0, 1'b1);
    total += 3;
    if (err !== 8'h00) begin bad++; $display("FAIL clr_only_err: got %0h want 0", err); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_only_valid: got %0b want 1", out_valid); end
    if (out_data !== exp_q[0].d) begin bad++; $display("FAIL clr_only_data: got %0h want %0h", out_data, exp_q[0].d); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 127, 1'b1, (i == 0));
      total += 4;
      if (out_data !== 4'h7) begin bad++; $display("FAIL sat_hi_data[%0d]: got %0h want 7", i, out_data); end
      if (out_sat !== 1'b1) begin bad++; $display("FAIL sat_hi_flag[%0d]: got %0b want 1", i, out_sat); end
      if (err !== 8'h0F) begin bad++; $display("FAIL sat_hi_err[%0d]: got %0h want 0f", i, err); end
      if (out_sat !== exp_q[0].s) begin bad++; $display("FAIL sat_hi_model[%0d]: got %0b want %0b", i, out_sat, exp_q[0].s); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, -128, 1'b1, (i == 0));
      total += 3;
      if (out_data !== 4'h8) begin bad++; $display("FAIL sat_lo_data[%0d]: got %0h want 8", i, out_data); end
      if (out_sat !== 1'b0) begin bad++; $display("FAIL sat_lo_flag[%0d]: got %0b want 0", i, out_sat); end
      if (err !== 8'h00) begin bad++; $display("FAIL sat_lo_err[%0d]: got %0h want 0", i, err); end
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 0, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3, 1'b0, 1'b0);
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
      if (out_data !== 4'h0) begin bad++; $display("FAIL bp_data[%0d]: got %0h want 0", i, out_data); end
      if (err !== 8'h03) begin bad++; $display("FAIL bp_err[%0d]: got %0h want 03", i, err); end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
    drive(1'b1, 3, 1'b1, 1'b0);
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_release_valid: got %0b want 1", out_valid); end
    if (out_data !== exp_q[0].d) begin bad++; $display("FAIL bp_release_data: got %0h want %0h", out_data, exp_q[0].d); end
    if (err !== 8'h06) begin bad++; $display("FAIL bp_release_err: got %0h want 06", err); end
  endtask

  task automatic test_async_reset();
    logic [3:0] d4;
    logic [7:0] e8;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    if (err !== 8'h00) begin bad++; $display("FAIL arst_err: got %0h want 0", err); end
    if (out_data !== 4'h0) begin bad++; $display("FAIL arst_data: got %0h want 0", out_data); end
    m_err = 0; m_vld = 1'b0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5, 1'b1, 1'b0);
      d4 = 4'(dtab[i]);
      e8 = 8'(etab[i]);
      total += 2;
      if (out_data !== d4) begin bad++; $display("FAIL arst_restart_data[%0d]: got %0h want %0h", i, out_data, d4); end
      if (err !== e8) begin bad++; $display("FAIL arst_restart_err[%0d]: got %0h want %0h", i, err, e8); end
    end
  endtask

  initial begin
    clk = 1'b0;
    total = 0;
    bad = 0;
    m_err = 0;
    m_vld = 1'b0;
    test_reset();
    test_dc_stream();
    test_clear();
    test_saturation();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
